// File: rtl/riscv.sv
// Single-cycle RV32I subset core: R/I ALU ops, lb/lw/sb/sw, beq/bne.
// Instruction, register and data storage live in named sub-instances.
module riscv_imem (
    input  logic        clk,
    input  logic        we,
    input  logic [5:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [5:0]  addr,
    output logic [31:0] data
);
    logic [31:0] mem [64];

    // Write port is tied off in the core; contents are preloaded externally.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign data = mem[addr];
endmodule

module riscv_regs (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (we && wa != 5'd0) regs[wa] <= wd;
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
endmodule

module riscv_dmem (
    input  logic        clk,
    input  logic        web,
    input  logic        wew,
    input  logic [6:0]  addr,
    input  logic [31:0] wd,
    output logic [31:0] rd
);
    logic [7:0] mem [128];
    logic [6:0] a1, a2, a3;

    // Word lanes wrap modulo 128 through 7-bit adds.
    assign a1 = addr + 7'd1;
    assign a2 = addr + 7'd2;
    assign a3 = addr + 7'd3;

    always_ff @(posedge clk) begin
        if (web || wew) mem[addr] <= wd[7:0];
        if (wew) begin
            mem[a1] <= wd[15:8];
            mem[a2] <= wd[23:16];
            mem[a3] <= wd[31:24];
        end
    end

    assign rd = {mem[a3], mem[a2], mem[a1], mem[addr]};
endmodule

module riscv (
    input logic clk,
    input logic reset
);
    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
        ALU_XOR, ALU_SLL, ALU_SRL
    } aluop_t;

    logic [31:0] pc, pcn, instr;
    logic [31:0] rs1v, rs2v, opb, alu, imm;
    logic [31:0] immi, imms, immb;
    logic [31:0] memrd, ldv, wbv;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic        rwe, useimm, isld, ldbyte;
    logic        web, wew, isbr, brne, taken;
    aluop_t      op;

    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl;
    logic i_addi, i_andi, i_ori, i_xori;
    logic i_lb, i_lw, i_sb, i_sw, i_beq, i_bne;
    logic rop, iop, lop, sop, bop;

    riscv_imem instmemo (
        .clk   (clk),
        .we    (1'b0),
        .waddr (6'd0),
        .wdata (32'd0),
        .addr  (pc[7:2]),
        .data  (instr)
    );

    riscv_regs regs (
        .clk (clk),
        .we  (rwe & ~reset),
        .ra1 (instr[19:15]),
        .ra2 (instr[24:20]),
        .wa  (instr[11:7]),
        .wd  (wbv),
        .rd1 (rs1v),
        .rd2 (rs2v)
    );

    riscv_dmem datamem (
        .clk  (clk),
        .web  (web & ~reset),
        .wew  (wew & ~reset),
        .addr (alu[6:0]),
        .wd   (rs2v),
        .rd   (memrd)
    );

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    assign immi = {{20{instr[31]}}, instr[31:20]};
    assign imms = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign immb = {{19{instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};

    assign rop = (opc == 7'h33);
    assign iop = (opc == 7'h13);
    assign lop = (opc == 7'h03);
    assign sop = (opc == 7'h23);
    assign bop = (opc == 7'h63);

    assign i_add  = rop && f3 == 3'd0 && f7 == 7'h00;
    assign i_sub  = rop && f3 == 3'd0 && f7 == 7'h20;
    assign i_sll  = rop && f3 == 3'd1 && f7 == 7'h00;
    assign i_xor  = rop && f3 == 3'd4 && f7 == 7'h00;
    assign i_srl  = rop && f3 == 3'd5 && f7 == 7'h00;
    assign i_or   = rop && f3 == 3'd6 && f7 == 7'h00;
    assign i_and  = rop && f3 == 3'd7 && f7 == 7'h00;
    assign i_addi = iop && f3 == 3'd0;
    assign i_xori = iop && f3 == 3'd4;
    assign i_ori  = iop && f3 == 3'd6;
    assign i_andi = iop && f3 == 3'd7;
    assign i_lb   = lop && f3 == 3'd0;
    assign i_lw   = lop && f3 == 3'd2;
    assign i_sb   = sop && f3 == 3'd0;
    assign i_sw   = sop && f3 == 3'd2;
    assign i_beq  = bop && f3 == 3'd0;
    assign i_bne  = bop && f3 == 3'd1;

    // Anything not matched falls to default and behaves as a NOP.
    always_comb begin
        op     = ALU_ADD;
        imm    = immi;
        rwe    = 1'b0;
        useimm = 1'b0;
        isld   = 1'b0;
        ldbyte = 1'b0;
        web    = 1'b0;
        wew    = 1'b0;
        isbr   = 1'b0;
        brne   = 1'b0;
        unique case (1'b1)
            i_add:  rwe = 1'b1;
            i_sub:  begin rwe = 1'b1; op = ALU_SUB; end
            i_and:  begin rwe = 1'b1; op = ALU_AND; end
            i_or:   begin rwe = 1'b1; op = ALU_OR;  end
            i_xor:  begin rwe = 1'b1; op = ALU_XOR; end
            i_sll:  begin rwe = 1'b1; op = ALU_SLL; end
            i_srl:  begin rwe = 1'b1; op = ALU_SRL; end
            i_addi: begin rwe = 1'b1; useimm = 1'b1; end
            i_andi: begin rwe = 1'b1; useimm = 1'b1; op = ALU_AND; end
            i_ori:  begin rwe = 1'b1; useimm = 1'b1; op = ALU_OR;  end
            i_xori: begin rwe = 1'b1; useimm = 1'b1; op = ALU_XOR; end
            i_lb:   begin
                rwe = 1'b1; useimm = 1'b1;
                isld = 1'b1; ldbyte = 1'b1;
            end
            i_lw:   begin rwe = 1'b1; useimm = 1'b1; isld = 1'b1; end
            i_sb:   begin useimm = 1'b1; imm = imms; web = 1'b1; end
            i_sw:   begin useimm = 1'b1; imm = imms; wew = 1'b1; end
            i_beq:  isbr = 1'b1;
            i_bne:  begin isbr = 1'b1; brne = 1'b1; end
            default: ;
        endcase
    end

    assign opb = useimm ? imm : rs2v;

    always_comb begin
        alu = rs1v + opb;
        unique case (op)
            ALU_ADD: alu = rs1v + opb;
            ALU_SUB: alu = rs1v - opb;
            ALU_AND: alu = rs1v & opb;
            ALU_OR:  alu = rs1v | opb;
            ALU_XOR: alu = rs1v ^ opb;
            ALU_SLL: alu = rs1v << opb[4:0];
            ALU_SRL: alu = rs1v >> opb[4:0];
            default: alu = rs1v + opb;
        endcase
    end

    assign ldv = ldbyte ? {{24{memrd[7]}}, memrd[7:0]} : memrd;
    assign wbv = isld ? ldv : alu;

    assign taken = isbr & ((rs1v == rs2v) ^ brne);
    assign pcn   = taken ? pc + immb : pc + 32'd4;

    // Instruction memory spans 256 bytes, so the PC wraps there.
    always_ff @(posedge clk) begin
        if (reset) pc <= '0;
        else       pc <= pcn & 32'h0000_00ff;
    end
endmodule

// File: tb/tb_riscv.sv
// Bench for riscv: ISA-level model runs in lockstep; a monitor compares
// PC, register file and data memory after every clock edge.
module tb_riscv;
    logic clk = 1'b0;
    logic reset = 1'b1;

    riscv dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    typedef enum int {
        K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLL, K_SRL,
        K_ADDI, K_ANDI, K_ORI, K_XORI,
        K_LB, K_LW, K_SB, K_SW, K_BEQ, K_BNE, K_NOP
    } kind_e;

    typedef struct {
        kind_e       k;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] word;
    } ins_t;

    typedef struct {
        logic [31:0]   pc;
        logic [1023:0] r;
        logic [1023:0] m;
    } exp_t;

    ins_t        prog [64];
    logic [31:0] m_regs [32];
    logic [7:0]  m_mem [128];
    logic [31:0] m_pc;
    exp_t        q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic ins_t mk(kind_e k, int rd, int rs1, int rs2, int imm);
        ins_t t;
        t.k = k; t.rd = 5'(rd); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2);
        t.imm = 32'(imm); t.word = 32'd0;
        return t;
    endfunction

    function automatic logic [31:0] rtype(logic [6:0] f7, logic [2:0] f3, ins_t t);
        return {f7, t.rs2, t.rs1, f3, t.rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc(ins_t t);
        logic [31:0] i;
        i = t.imm;
        case (t.k)
            K_ADD:  return rtype(7'h00, 3'd0, t);
            K_SUB:  return rtype(7'h20, 3'd0, t);
            K_SLL:  return rtype(7'h00, 3'd1, t);
            K_XOR:  return rtype(7'h00, 3'd4, t);
            K_SRL:  return rtype(7'h00, 3'd5, t);
            K_OR:   return rtype(7'h00, 3'd6, t);
            K_AND:  return rtype(7'h00, 3'd7, t);
            K_ADDI: return {i[11:0], t.rs1, 3'd0, t.rd, 7'h13};
            K_XORI: return {i[11:0], t.rs1, 3'd4, t.rd, 7'h13};
            K_ORI:  return {i[11:0], t.rs1, 3'd6, t.rd, 7'h13};
            K_ANDI: return {i[11:0], t.rs1, 3'd7, t.rd, 7'h13};
            K_LB:   return {i[11:0], t.rs1, 3'd0, t.rd, 7'h03};
            K_LW:   return {i[11:0], t.rs1, 3'd2, t.rd, 7'h03};
            K_SB:   return {i[11:5], t.rs2, t.rs1, 3'd0, i[4:0], 7'h23};
            K_SW:   return {i[11:5], t.rs2, t.rs1, 3'd2, i[4:0], 7'h23};
            K_BEQ:  return {i[12], i[10:5], t.rs2, t.rs1, 3'd0, i[4:1], i[11], 7'h63};
            K_BNE:  return {i[12], i[10:5], t.rs2, t.rs1, 3'd1, i[4:1], i[11], 7'h63};
            default: return t.word;
        endcase
    endfunction

    function automatic ins_t rand_ins();
        ins_t t;
        logic [11:0] r12;
        logic [31:0] nops [6];
        int off;
        nops = '{32'h0000_0000, 32'h0031_1093, 32'h0000_C063,
                 32'h0010_1083, 32'h4000_50B3, 32'h0000_10B7};
        t.k   = kind_e'($urandom_range(0, 17));
        t.rd  = 5'($urandom);
        t.rs1 = 5'($urandom);
        t.rs2 = 5'($urandom);
        r12   = 12'($urandom);
        t.imm = {{20{r12[11]}}, r12};
        t.word = nops[$urandom_range(0, 5)];
        if (t.k == K_BEQ || t.k == K_BNE) begin
            off = (int'($urandom_range(0, 12)) - 4) * 4;
            t.imm = 32'(off);
        end
        return t;
    endfunction

    function automatic void setr(logic [4:0] rd, logic [31:0] v);
        if (rd != 5'd0) m_regs[rd] = v;
    endfunction

    // Architectural effect of one instruction, taken from the ISA rules.
    task automatic model_step();
        ins_t t;
        logic [31:0] a, b, nxt, ea;
        int ad;
        t   = prog[m_pc[7:2]];
        a   = m_regs[t.rs1];
        b   = m_regs[t.rs2];
        nxt = m_pc + 4;
        ea  = a + t.imm;
        ad  = int'(ea % 128);
        case (t.k)
            K_ADD:  setr(t.rd, a + b);
            K_SUB:  setr(t.rd, a - b);
            K_AND:  setr(t.rd, a & b);
            K_OR:   setr(t.rd, a | b);
            K_XOR:  setr(t.rd, a ^ b);
            K_SLL:  setr(t.rd, a << (b % 32));
            K_SRL:  setr(t.rd, a >> (b % 32));
            K_ADDI: setr(t.rd, a + t.imm);
            K_ANDI: setr(t.rd, a & t.imm);
            K_ORI:  setr(t.rd, a | t.imm);
            K_XORI: setr(t.rd, a ^ t.imm);
            K_LB:   setr(t.rd, 32'(signed'(m_mem[ad])));
            K_LW:   setr(t.rd, {m_mem[(ad + 3) % 128], m_mem[(ad + 2) % 128],
                                m_mem[(ad + 1) % 128], m_mem[ad]});
            K_SB:   m_mem[ad] = b[7:0];
            K_SW:   for (int k = 0; k < 4; k++) m_mem[(ad + k) % 128] = b[8*k +: 8];
            K_BEQ:  if (a == b) nxt = m_pc + t.imm;
            K_BNE:  if (a != b) nxt = m_pc + t.imm;
            default: ;
        endcase
        m_pc = nxt % 256;
    endtask

    function automatic exp_t snap();
        exp_t s;
        s.pc = m_pc;
        for (int i = 0; i < 32; i++) s.r[i*32 +: 32] = m_regs[i];
        for (int i = 0; i < 128; i++) s.m[i*8 +: 8] = m_mem[i];
        return s;
    endfunction

    task automatic load_dut();
        for (int i = 0; i < 64; i++) dut.instmemo.mem[i] = enc(prog[i]);
        for (int i = 0; i < 32; i++) dut.regs.regs[i] = m_regs[i];
        for (int i = 0; i < 128; i++) dut.datamem.mem[i] = m_mem[i];
    endtask

    // Drive one clock: predict its effect, queue it, wait for the next negedge.
    task automatic cycle(input bit rst);
        reset = rst;
        if (rst) m_pc = 32'd0;
        else     model_step();
        q.push_back(snap());
        @(negedge clk);
    endtask

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic [1023:0] gr, gm;
        int idx;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int i = 0; i < 32; i++) gr[i*32 +: 32] = dut.regs.regs[i];
                for (int i = 0; i < 128; i++) gm[i*8 +: 8] = dut.datamem.mem[i];
                n_cmp += 3;
                if (dut.pc !== e.pc) begin
                    n_bad++;
                    $display("FAIL pc @%0t: got %08h expected %08h", $time, dut.pc, e.pc);
                end
                if (gr !== e.r) begin
                    n_bad++;
                    idx = 0;
                    for (int i = 31; i >= 0; i--)
                        if (gr[i*32 +: 32] !== e.r[i*32 +: 32]) idx = i;
                    $display("FAIL regs x%0d @%0t: got %08h expected %08h",
                             idx, $time, gr[idx*32 +: 32], e.r[idx*32 +: 32]);
                end
                if (gm !== e.m) begin
                    n_bad++;
                    idx = 0;
                    for (int i = 127; i >= 0; i--)
                        if (gm[i*8 +: 8] !== e.m[i*8 +: 8]) idx = i;
                    $display("FAIL dmem[%0d] @%0t: got %02h expected %02h",
                             idx, $time, gm[idx*8 +: 8], e.m[idx*8 +: 8]);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Directed program exercising the listed corner behaviours.
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        for (int i = 0; i < 128; i++) m_mem[i] = 8'h00;
        for (int i = 0; i < 64; i++) prog[i] = mk(K_NOP, 0, 0, 0, 0);
        m_regs[10] = 32'h0000_000C; m_regs[11] = 32'd2;
        m_regs[12] = 32'h0000_000F;
        m_regs[16] = 32'h8000_0000; m_regs[17] = 32'd31;
        m_mem[0] = 8'h07; m_mem[1] = 8'hF0;
        m_mem[3] = 8'hAA; m_mem[5] = 8'h55;
        prog[0]  = mk(K_LB,   5, 1, 0, 0);
        prog[1]  = mk(K_ADDI, 6, 0, 0, 5);
        prog[2]  = mk(K_SUB,  6, 6, 6, 0);
        prog[3]  = mk(K_AND,  7, 6, 5, 0);
        prog[4]  = mk(K_ORI,  8, 0, 0, 'h0F0);
        prog[5]  = mk(K_ADDI, 13, 0, 0, 8);
        prog[6]  = mk(K_SLL,  14, 8, 13, 0);
        prog[7]  = mk(K_OR,   8, 8, 14, 0);
        prog[8]  = mk(K_SRL,  9, 10, 11, 0);
        prog[9]  = mk(K_SB,   0, 1, 12, 4);
        prog[10] = mk(K_ADDI, 0, 0, 0, 9);
        prog[11] = mk(K_BNE,  0, 0, 0, 8);
        prog[12] = mk(K_SRL,  15, 16, 17, 0);
        prog[13] = mk(K_LB,   18, 1, 0, 1);
        prog[14] = mk(K_BEQ,  0, 0, 0, -4);
        load_dut();
        cycle(1);
        cycle(1);
        for (int c = 0; c < 22; c++) cycle(0);

        chk("lb_pos_x5",   dut.regs.regs[5],  32'h0000_0007);
        chk("sub_self_x6", dut.regs.regs[6],  32'h0000_0000);
        chk("and_x7",      dut.regs.regs[7],  32'h0000_0000);
        chk("shift_or_x8", dut.regs.regs[8],  32'h0000_F0F0);
        chk("srl_x9",      dut.regs.regs[9],  32'h0000_0003);
        chk("srl_msb_x15", dut.regs.regs[15], 32'h0000_0001);
        chk("lb_neg_x18",  dut.regs.regs[18], 32'hFFFF_FFF0);
        chk("x0_zero",     dut.regs.regs[0],  32'h0000_0000);
        chk("sb_mem4",     32'(dut.datamem.mem[4]), 32'h0000_000F);
        chk("sb_mem3",     32'(dut.datamem.mem[3]), 32'h0000_00AA);
        chk("sb_mem5",     32'(dut.datamem.mem[5]), 32'h0000_0055);
        chk("beq_loop_pc", 32'(dut.pc == 32'd52 || dut.pc == 32'd56), 32'd1);

        cycle(1);
        chk("reset_pc",    dut.pc,            32'h0000_0000);
        chk("reset_keep_x8", dut.regs.regs[8], 32'h0000_F0F0);
        cycle(0);
        chk("restart_x5",  dut.regs.regs[5],  32'h0000_0007);

        // Random programs with occasional mid-program resets.
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 64; i++) prog[i] = rand_ins();
            m_regs[0] = 32'd0;
            for (int i = 1; i < 32; i++) m_regs[i] = $urandom;
            for (int i = 0; i < 128; i++) m_mem[i] = 8'($urandom);
            load_dut();
            cycle(1);
            for (int c = 0; c < 160; c++) cycle($urandom_range(0, 39) == 0);
        end

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected states never checked", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
